mem_arb: RTL and testbench

Two-requester arbiter and burst sequencer for the single main-memory port shared by the instruction cache (port 0) and data cache (port 1). It grants one cache line transaction at a time using round-robin priority, then issues one burst of BURST_LEN word beats to memory. Read data returns to the granted cache, and write data is pulled from it. It sits between the icache/dcache miss logic and the memory interface of the core.

---
 rtl/mem_arb.sv | 167 ++++++++++++++++
 tb/tb_mem_arb.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb.sv
// Round-robin arbiter between icache (port 0) and dcache (port 1) for the shared
// main-memory port; each grant runs one line burst of BURST_LEN word beats.
module mem_arb #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m1_req,
    input  logic              m0_wen,
    input  logic              m1_wen,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m0_wnext,
    output logic              m1_wnext,
    output logic              m0_rvalid,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m0_done,
    output logic              m1_done,
    output logic              mem_req,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int CNT_W = $clog2(BURST_LEN);
    localparam int OFF_W = CNT_W + 2;
    localparam logic [ADDR_W-1:0] BASE_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BURST_LEN - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BURST = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] base_q, base_d;

    logic [1:0]        req_v;
    logic [1:0]        wen_v;
    logic [ADDR_W-1:0] addr_v  [2];
    logic [DATA_W-1:0] wdata_v [2];
    logic [1:0]        rvalid_o, wnext_o, done_o;
    logic [DATA_W-1:0] rdata_o [2];
    logic              beat_accept;
    logic              pick;

    assign req_v      = {m1_req, m0_req};
    assign wen_v      = {m1_wen, m0_wen};
    assign addr_v[0]  = m0_addr;
    assign addr_v[1]  = m1_addr;
    assign wdata_v[0] = m0_wdata;
    assign wdata_v[1] = m1_wdata;

    assign beat_accept = (state_q == S_BURST) && mem_ready;

    // On a tie, port 1 wins only if port 0 was granted last.
    assign pick = req_v[1] & (~req_v[0] | ~last_grant_q);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        wen_d        = wen_q;
        base_d       = base_q;
        case (state_q)
            S_IDLE: begin
                if (|req_v) begin
                    grant_d      = pick;
                    last_grant_d = pick;
                    wen_d        = wen_v[pick];
                    base_d       = addr_v[pick] & BASE_MASK;
                    cnt_d        = '0;
                    state_d      = S_BURST;
                end
            end
            S_BURST: begin
                if (mem_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            wen_q        <= 1'b0;
            base_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            wen_q        <= wen_d;
            base_q       <= base_d;
        end
    end

    // The beat counter only ever touches line-internal bits, so OR-ing is carry-free.
    assign mem_req   = (state_q == S_BURST);
    assign mem_wen   = (state_q == S_BURST) & wen_q;
    assign mem_addr  = base_q | (ADDR_W'(cnt_q) << 2);
    assign mem_wdata = wdata_v[grant_q];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic              sel;
            logic              rvalid_q, rvalid_d;
            logic [DATA_W-1:0] rdata_q, rdata_d;

            assign sel = (grant_q == 1'(gi));

            always_comb begin
                rvalid_d = beat_accept & ~wen_q & sel;
                rdata_d  = rdata_q;
                if (rvalid_d) begin
                    rdata_d = mem_rdata;
                end
            end

            always_ff @(posedge clk) begin
                if (!reset) begin
                    rvalid_q <= 1'b0;
                    rdata_q  <= '0;
                end else begin
                    rvalid_q <= rvalid_d;
                    rdata_q  <= rdata_d;
                end
            end

            assign rvalid_o[gi] = rvalid_q;
            assign rdata_o[gi]  = rdata_q;
            assign wnext_o[gi]  = beat_accept & wen_q & sel;
            assign done_o[gi]   = (state_q == S_DONE) & sel;
        end
    endgenerate

    assign m0_rvalid = rvalid_o[0];
    assign m1_rvalid = rvalid_o[1];
    assign m0_rdata  = rdata_o[0];
    assign m1_rdata  = rdata_o[1];
    assign m0_wnext  = wnext_o[0];
    assign m1_wnext  = wnext_o[1];
    assign m0_done   = done_o[0];
    assign m1_done   = done_o[1];
endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: a memory responder plus a scoreboard of expected beats,
// read returns and done pulses, popped as the arbiter produces them.
module tb_mem_arb;
    localparam int BL     = 4;
    localparam int WBASE0 = 200;
    localparam int WBASE1 = 100;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic        m0_wen = 1'b0, m1_wen = 1'b0;
    logic [31:0] m0_addr = '0, m1_addr = '0;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_wnext, m1_wnext, m0_rvalid, m1_rvalid, m0_done, m1_done;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_req, mem_wen;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ready = 1'b1;

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] data;
        logic        port;
    } beat_t;
    typedef struct {
        logic        port;
        logic [31:0] data;
    } rd_t;

    beat_t beat_q[$];
    rd_t   rd_q[$];
    logic  done_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int wcnt[2];
    int wpush[2];
    int txn_left[2];
    logic wflag[2];
    int mode = 0;
    int beats_seen = 0;

    always #5 clk = ~clk;

    mem_arb #(.ADDR_W(32), .DATA_W(32), .BURST_LEN(BL)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m1_req(m1_req), .m0_wen(m0_wen), .m1_wen(m1_wen),
        .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_wnext(m0_wnext), .m1_wnext(m1_wnext), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata), .m0_done(m0_done), .m1_done(m1_done),
        .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        return {a[27:4], 8'hA0 + {6'd0, a[3:2]}};
    endfunction

    assign mem_rdata = rd_model(mem_addr);
    assign m0_wdata  = 32'(WBASE0 + wcnt[0]);
    assign m1_wdata  = 32'(WBASE1 + wcnt[1]);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void push_txn(input logic p, input logic w, input logic [31:0] a);
        logic [31:0] base;
        beat_t b;
        rd_t r;
        base = a & ~32'hF;
        for (int k = 0; k < BL; k++) begin
            b.addr = base + 32'(4 * k);
            b.wen  = w;
            b.port = p;
            b.data = '0;
            if (w) begin
                b.data = 32'((p ? WBASE1 : WBASE0) + wpush[p]);
                wpush[p]++;
            end else begin
                r.port = p;
                r.data = rd_model(b.addr);
                rd_q.push_back(r);
            end
            beat_q.push_back(b);
        end
        done_q.push_back(p);
    endfunction

    task automatic drive(input logic p, input logic w, input logic [31:0] a, input int n);
        txn_left[p] = n;
        if (p) begin
            m1_wen = w; m1_addr = a; m1_req = 1'b1;
        end else begin
            m0_wen = w; m0_addr = a; m0_req = 1'b1;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && (beat_q.size() + rd_q.size() + done_q.size()) > 0; i++) begin
            @(negedge clk); #1;
        end
        check("idle_timeout", 32'(beat_q.size() + rd_q.size() + done_q.size()), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_wen"}, {mem_req, mem_wen}, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_flags"}, {m0_rvalid, m1_rvalid, m0_done, m1_done, m0_wnext, m1_wnext}, 0);
        check({tag, "_rdata0"}, m0_rdata, 0);
        check({tag, "_rdata1"}, m1_rdata, 0);
    endtask

    // Memory responder: advance write words after wnext, shape mem_ready.
    always @(posedge clk) begin
        #1;
        for (int p = 0; p < 2; p++) begin
            if (wflag[p]) begin
                wcnt[p]++;
                wflag[p] = 1'b0;
            end
        end
        case (mode)
            0:       mem_ready = 1'b1;
            1:       mem_ready = ~mem_ready;
            default: mem_ready = 1'b0;
        endcase
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        beat_t b;
        rd_t   r;
        logic  p;
        if (mem_req && mem_ready) begin
            beats_seen++;
            if (beat_q.size() == 0) begin
                check("beat_unexp", 32'(beat_q.size()), 1);
            end else begin
                b = beat_q.pop_front();
                check("beat_addr", mem_addr, b.addr);
                check("beat_wen", {31'd0, mem_wen}, {31'd0, b.wen});
                if (b.wen) check("beat_wdata", mem_wdata, b.data);
                check("wnext", {m1_wnext, m0_wnext}, b.wen ? (b.port ? 2'b10 : 2'b01) : 2'b00);
            end
            if (m0_wnext) wflag[0] = 1'b1;
            if (m1_wnext) wflag[1] = 1'b1;
        end else begin
            check("wnext_quiet", {m1_wnext, m0_wnext}, 0);
            if (mem_req && beat_q.size() > 0) begin
                check("hold_addr", mem_addr, beat_q[0].addr);
                if (beat_q[0].wen) check("hold_wdata", mem_wdata, beat_q[0].data);
            end
        end
        if (m0_rvalid || m1_rvalid) begin
            if (rd_q.size() == 0) begin
                check("rvalid_unexp", {m1_rvalid, m0_rvalid}, 0);
            end else begin
                r = rd_q.pop_front();
                check("rv_port", {m1_rvalid, m0_rvalid}, r.port ? 2'b10 : 2'b01);
                check("rdata", r.port ? m1_rdata : m0_rdata, r.data);
            end
        end
        if (m0_done || m1_done) begin
            if (done_q.size() == 0) begin
                check("done_unexp", {m1_done, m0_done}, 0);
            end else begin
                p = done_q.pop_front();
                check("done_port", {m1_done, m0_done}, p ? 2'b10 : 2'b01);
                if (txn_left[p] > 0) txn_left[p]--;
                if (txn_left[p] == 0) begin
                    if (p) m1_req = 1'b0;
                    else   m0_req = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        for (int p = 0; p < 2; p++) begin
            wcnt[p] = 0; wpush[p] = 0; txn_left[p] = 0; wflag[p] = 1'b0;
        end
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check_reset_outputs("rst");
        reset = 1'b1;
        @(negedge clk); #1;

        // Single m0 read with one-cycle grant latency.
        push_txn(1'b0, 1'b0, 32'h1234);
        drive(1'b0, 1'b0, 32'h1234, 1);
        @(negedge clk); #1;
        check("grant_lat", {31'd0, mem_req}, 1);
        check("grant_addr", mem_addr, 32'h1230);
        wait_idle();

        // Single m1 write with mem_ready toggling.
        mode = 1;
        push_txn(1'b1, 1'b1, 32'h40);
        drive(1'b1, 1'b1, 32'h40, 1);
        wait_idle();
        mode = 0;

        // Contention from reset: expect m0, m1, m0.
        reset = 1'b0;
        @(negedge clk); #1;
        push_txn(1'b0, 1'b0, 32'h0000_0A00);
        push_txn(1'b1, 1'b0, 32'h0000_0B00);
        push_txn(1'b0, 1'b0, 32'h0000_0A00);
        drive(1'b0, 1'b0, 32'h0000_0A00, 2);
        drive(1'b1, 1'b0, 32'h0000_0B00, 1);
        reset = 1'b1;
        wait_idle();
        repeat (2) begin
            @(negedge clk); #1;
        end

        // Requester drops req mid-burst; no regrant afterwards.
        push_txn(1'b0, 1'b0, 32'h2000);
        drive(1'b0, 1'b0, 32'h2000, 1);
        @(negedge clk); #1;
        check("drop_granted", {31'd0, mem_req}, 1);
        m0_req = 1'b0;
        wait_idle();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            check("no_regrant", {31'd0, mem_req}, 0);
        end

        // Long stall on an m1 write.
        mode = 2;
        push_txn(1'b1, 1'b1, 32'h300);
        drive(1'b1, 1'b1, 32'h300, 1);
        @(negedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            check("stall_flags", {mem_req, m0_rvalid, m1_rvalid, m0_wnext, m1_wnext, m0_done, m1_done}, 7'b1000000);
            check("stall_addr", mem_addr, 32'h300);
            @(negedge clk); #1;
        end
        mode = 0;
        wait_idle();

        // Reset in the middle of an m0 read, then m1 restarts from its base.
        beats_seen = 0;
        push_txn(1'b0, 1'b0, 32'h5000);
        drive(1'b0, 1'b0, 32'h5000, 1);
        for (int i = 0; i < 50 && beats_seen < 2; i++) begin
            @(negedge clk); #1;
        end
        check("mid_beats", 32'(beats_seen), 2);
        reset = 1'b0;
        beat_q.delete();
        rd_q.delete();
        done_q.delete();
        txn_left[0] = 0;
        m0_req = 1'b0;
        drive(1'b1, 1'b0, 32'h601C, 1);
        @(negedge clk); #1;
        check_reset_outputs("midrst");
        push_txn(1'b1, 1'b0, 32'h601C);
        reset = 1'b1;
        @(negedge clk); #1;
        check("post_rst_req", {31'd0, mem_req}, 1);
        check("post_rst_addr", mem_addr, 32'h6010);
        wait_idle();

        repeat (3) begin
            @(negedge clk); #1;
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
